// File: rtl/pspin_pkt_alloc.sv
// pspin_pkt_alloc: packet-buffer slot allocator for the PsPIN ingress path.
//   Allocates fixed-size L2 slots to incoming packets (lowest free slot first)
//   and releases them on handler-completion feedback.
//   clk, rstn                      : clock, synchronous active-low reset
//   pkt_len/tag/valid, pkt_ready   : allocation request from the matching engine
//   write_addr/len/tag/valid/ready : allocation result to the ingress DMA
//   feedback_addr/valid            : slot release, always accepted
//   slots_used                     : number of allocated slots
//   alloc_cnt/drop_cnt/bad_free_cnt: statistics, present only when
//                                    PSPIN_ALLOC_STATS_EN is defined (else 0)
module pspin_pkt_alloc #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        LEN_WIDTH      = 20,
    parameter int                        TAG_WIDTH      = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] BUF_START      = 'h1000_0000,
    parameter int                        SLOT_SIZE      = 2048,
    parameter int                        NUM_SLOTS      = 64
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [LEN_WIDTH-1:0]          pkt_len,
    input  logic [TAG_WIDTH-1:0]          pkt_tag,
    input  logic                          pkt_valid,
    output logic                          pkt_ready,
    output logic [AXI_ADDR_WIDTH-1:0]     write_addr,
    output logic [LEN_WIDTH-1:0]          write_len,
    output logic [TAG_WIDTH-1:0]          write_tag,
    output logic                          write_valid,
    input  logic                          write_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     feedback_addr,
    input  logic                          feedback_valid,
    output logic [$clog2(NUM_SLOTS):0]    slots_used,
    output logic [31:0]                   alloc_cnt,
    output logic [31:0]                   drop_cnt,
    output logic [31:0]                   bad_free_cnt
);
    localparam int IDX_W     = $clog2(NUM_SLOTS);
    localparam int CNT_W     = IDX_W + 1;
    localparam int SLOT_BITS = $clog2(SLOT_SIZE);
    localparam logic [AXI_ADDR_WIDTH-1:0] REGION  = AXI_ADDR_WIDTH'(NUM_SLOTS * SLOT_SIZE);
    localparam logic [LEN_WIDTH-1:0]      MAX_LEN = LEN_WIDTH'(SLOT_SIZE);

    logic [NUM_SLOTS-1:0]      bitmap_q, bitmap_d;
    logic [CNT_W-1:0]          used_q, used_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [TAG_WIDTH-1:0]      tag_q, tag_d;
    logic                      wvalid_q, wvalid_d;
    logic [IDX_W-1:0]          alloc_idx, free_idx;
    logic [AXI_ADDR_WIDTH-1:0] fb_off;
    logic                      len_ok, do_alloc, fb_ok, do_free;

    // Scan downwards so the lowest free index wins.
    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (!bitmap_q[i]) alloc_idx = IDX_W'(i);
    end

    assign pkt_ready = rstn && !(&bitmap_q) && (!wvalid_q || write_ready);
    assign len_ok    = pkt_len != '0 && pkt_len <= MAX_LEN;
    assign do_alloc  = pkt_valid && pkt_ready && len_ok;

    // The >= guard rejects addresses below the region whose offset wraps around.
    assign fb_off   = feedback_addr - BUF_START;
    assign free_idx = fb_off[SLOT_BITS +: IDX_W];
    assign fb_ok    = feedback_addr >= BUF_START && fb_off < REGION &&
                      fb_off[SLOT_BITS-1:0] == '0 && bitmap_q[free_idx];
    assign do_free  = feedback_valid && fb_ok;

    // Alloc picks a free slot and free targets an allocated one, so they never collide;
    // a slot freed this cycle only becomes visible to the allocator next cycle.
    always_comb begin
        bitmap_d = bitmap_q;
        addr_d   = addr_q;
        len_d    = len_q;
        tag_d    = tag_q;
        wvalid_d = wvalid_q && !write_ready;
        if (do_alloc) begin
            bitmap_d[alloc_idx] = 1'b1;
            addr_d   = BUF_START + (AXI_ADDR_WIDTH'(alloc_idx) << SLOT_BITS);
            len_d    = pkt_len;
            tag_d    = pkt_tag;
            wvalid_d = 1'b1;
        end
        if (do_free) bitmap_d[free_idx] = 1'b0;
        used_d = used_q + CNT_W'(do_alloc) - CNT_W'(do_free);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bitmap_q <= '0;
            used_q   <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            tag_q    <= '0;
            wvalid_q <= 1'b0;
        end else begin
            bitmap_q <= bitmap_d;
            used_q   <= used_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            tag_q    <= tag_d;
            wvalid_q <= wvalid_d;
        end
    end

    assign write_addr  = addr_q;
    assign write_len   = len_q;
    assign write_tag   = tag_q;
    assign write_valid = wvalid_q;
    assign slots_used  = used_q;

`ifdef PSPIN_ALLOC_STATS_EN
    logic        do_drop, do_bad;
    logic [31:0] alloc_cnt_q, drop_cnt_q, bad_cnt_q;

    assign do_drop = pkt_valid && pkt_ready && !len_ok;
    assign do_bad  = feedback_valid && !fb_ok;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            alloc_cnt_q <= '0;
            drop_cnt_q  <= '0;
            bad_cnt_q   <= '0;
        end else begin
            alloc_cnt_q <= alloc_cnt_q + 32'(do_alloc);
            drop_cnt_q  <= drop_cnt_q + 32'(do_drop);
            bad_cnt_q   <= bad_cnt_q + 32'(do_bad);
        end
    end

    assign alloc_cnt    = alloc_cnt_q;
    assign drop_cnt     = drop_cnt_q;
    assign bad_free_cnt = bad_cnt_q;
`else
    assign alloc_cnt    = '0;
    assign drop_cnt     = '0;
    assign bad_free_cnt = '0;
`endif
endmodule

// File: tb/tb_pspin_pkt_alloc.sv
// tb_pspin_pkt_alloc: directed self-checking bench for pspin_pkt_alloc (4 slots of 2 KiB).
module tb_pspin_pkt_alloc;
`ifdef PSPIN_ALLOC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [19:0] pkt_len;
    logic [31:0] pkt_tag;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [31:0] write_addr;
    logic [19:0] write_len;
    logic [31:0] write_tag;
    logic        write_valid;
    logic        write_ready;
    logic [31:0] feedback_addr;
    logic        feedback_valid;
    logic [2:0]  slots_used;
    logic [31:0] alloc_cnt, drop_cnt, bad_free_cnt;

    int checks   = 0;
    int failures = 0;

    pspin_pkt_alloc #(
        .AXI_ADDR_WIDTH(32),
        .LEN_WIDTH     (20),
        .TAG_WIDTH     (32),
        .BUF_START     (32'h1000_0000),
        .SLOT_SIZE     (2048),
        .NUM_SLOTS     (4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .pkt_len       (pkt_len),
        .pkt_tag       (pkt_tag),
        .pkt_valid     (pkt_valid),
        .pkt_ready     (pkt_ready),
        .write_addr    (write_addr),
        .write_len     (write_len),
        .write_tag     (write_tag),
        .write_valid   (write_valid),
        .write_ready   (write_ready),
        .feedback_addr (feedback_addr),
        .feedback_valid(feedback_valid),
        .slots_used    (slots_used),
        .alloc_cnt     (alloc_cnt),
        .drop_cnt      (drop_cnt),
        .bad_free_cnt  (bad_free_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] st(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    task automatic chk_out(input string tag, input logic v, input logic [31:0] a,
                           input logic [31:0] l, input logic [31:0] t, input int used);
        chk({tag, "_valid"}, 32'(write_valid), 32'(v));
        chk({tag, "_addr"}, write_addr, a);
        chk({tag, "_len"}, 32'(write_len), l);
        chk({tag, "_tag"}, write_tag, t);
        chk({tag, "_used"}, 32'(slots_used), 32'(used));
    endtask

    logic [31:0] bad_fb [4] = '{32'h1000_0804, 32'h0FFF_F800, 32'h1000_0000, 32'h1000_0000};
    int          bad_used [4] = '{4, 4, 3, 3};

    initial begin
        rstn = 1'b0; pkt_valid = 1'b0; pkt_len = '0; pkt_tag = '0;
        write_ready = 1'b1; feedback_valid = 1'b0; feedback_addr = '0;
        tick; tick;
        chk_out("reset", 1'b0, 32'h0, 32'h0, 32'h0, 0);
        chk("reset_ready", 32'(pkt_ready), 32'h0);
        chk("reset_alloc_cnt", alloc_cnt, 32'h0);
        chk("reset_drop_cnt", drop_cnt, 32'h0);
        chk("reset_bad_cnt", bad_free_cnt, 32'h0);
        rstn = 1'b1;
        #1;
        chk("ready_after_reset", 32'(pkt_ready), 32'h1);

        // Fill all four slots back-to-back.
        pkt_valid = 1'b1; pkt_len = 20'd64;
        for (int i = 0; i < 4; i++) begin
            pkt_tag = 32'(i + 1);
            #1;
            chk("fill_ready", 32'(pkt_ready), 32'h1);
            tick;
            chk_out("fill", 1'b1, 32'h1000_0000 + 32'(i) * 32'h800, 32'd64, 32'(i + 1), i + 1);
        end
        pkt_tag = 32'd5;
        #1;
        chk("full_ready", 32'(pkt_ready), 32'h0);
        chk("full_alloc_cnt", alloc_cnt, st(4));
        tick;
        chk("full_wvalid_clear", 32'(write_valid), 32'h0);
        chk("full_used", 32'(slots_used), 32'd4);

        // Release slot 1 while full; request is still pending.
        feedback_addr = 32'h1000_0800; feedback_valid = 1'b1;
        #1;
        chk("free_same_cycle_ready", 32'(pkt_ready), 32'h0);
        tick;
        feedback_valid = 1'b0;
        #1;
        chk("free_next_ready", 32'(pkt_ready), 32'h1);
        chk("free_used", 32'(slots_used), 32'd3);
        tick;
        chk_out("refill", 1'b1, 32'h1000_0800, 32'd64, 32'd5, 4);
        chk("refill_alloc_cnt", alloc_cnt, st(5));
        pkt_valid = 1'b0;

        // Unaligned, below range, valid free, double free.
        for (int i = 0; i < 4; i++) begin
            feedback_addr = bad_fb[i]; feedback_valid = 1'b1;
            tick;
            chk("badfree_used", 32'(slots_used), 32'(bad_used[i]));
        end
        feedback_valid = 1'b0;
        chk("badfree_cnt", bad_free_cnt, st(3));

        // Length bounds: 2049 and 0 drop, 2048 allocates slot 0.
        pkt_valid = 1'b1; pkt_len = 20'd2049; pkt_tag = 32'd6;
        #1;
        chk("drop_ready", 32'(pkt_ready), 32'h1);
        tick;
        chk("drop_long_wvalid", 32'(write_valid), 32'h0);
        chk("drop_long_cnt", drop_cnt, st(1));
        chk("drop_long_used", 32'(slots_used), 32'd3);
        pkt_len = 20'd0;
        tick;
        chk("drop_zero_wvalid", 32'(write_valid), 32'h0);
        chk("drop_zero_cnt", drop_cnt, st(2));
        chk("drop_zero_used", 32'(slots_used), 32'd3);
        pkt_len = 20'd2048;
        tick;
        chk_out("maxlen", 1'b1, 32'h1000_0000, 32'd2048, 32'd6, 4);
        chk("maxlen_alloc_cnt", alloc_cnt, st(6));
        pkt_valid = 1'b0;

        // Same-cycle alloc and free: freed slot 1 is skipped, slot 2 taken.
        feedback_addr = 32'h1000_1000; feedback_valid = 1'b1;
        tick;
        chk("pre_same_used", 32'(slots_used), 32'd3);
        chk("pre_same_wvalid", 32'(write_valid), 32'h0);
        feedback_addr = 32'h1000_0800; pkt_valid = 1'b1; pkt_len = 20'd1; pkt_tag = 32'd7;
        tick;
        feedback_valid = 1'b0;
        chk_out("same_cycle", 1'b1, 32'h1000_1000, 32'd1, 32'd7, 3);
        chk("same_cycle_alloc_cnt", alloc_cnt, st(7));
        tick;
        chk_out("after_same", 1'b1, 32'h1000_0800, 32'd1, 32'd7, 4);
        chk("after_same_alloc_cnt", alloc_cnt, st(8));
        pkt_valid = 1'b0;

        // Output stall, then reset during the stall.
        feedback_addr = 32'h1000_1800; feedback_valid = 1'b1;
        tick;
        feedback_addr = 32'h1000_0000;
        tick;
        feedback_valid = 1'b0;
        chk("prestall_used", 32'(slots_used), 32'd2);
        write_ready = 1'b0; pkt_valid = 1'b1; pkt_len = 20'd100; pkt_tag = 32'hAB;
        tick;
        chk_out("stall_load", 1'b1, 32'h1000_0000, 32'd100, 32'hAB, 3);
        chk("stall_alloc_cnt", alloc_cnt, st(9));
        pkt_len = 20'd200; pkt_tag = 32'hCD;
        for (int i = 0; i < 5; i++) begin
            chk("stall_ready", 32'(pkt_ready), 32'h0);
            tick;
            chk_out("stall_hold", 1'b1, 32'h1000_0000, 32'd100, 32'hAB, 3);
        end
        rstn = 1'b0; feedback_addr = 32'h1000_0800; feedback_valid = 1'b1;
        #1;
        chk("inreset_ready", 32'(pkt_ready), 32'h0);
        tick;
        chk_out("midreset", 1'b0, 32'h0, 32'h0, 32'h0, 0);
        chk("midreset_alloc_cnt", alloc_cnt, 32'h0);
        chk("midreset_drop_cnt", drop_cnt, 32'h0);
        chk("midreset_bad_cnt", bad_free_cnt, 32'h0);
        rstn = 1'b1; feedback_valid = 1'b0; write_ready = 1'b1; pkt_len = 20'd64; pkt_tag = 32'h11;
        #1;
        chk("postreset_ready", 32'(pkt_ready), 32'h1);
        tick;
        chk_out("postreset", 1'b1, 32'h1000_0000, 32'd64, 32'h11, 1);
        chk("postreset_alloc_cnt", alloc_cnt, st(1));
        chk("postreset_bad_cnt", bad_free_cnt, 32'h0);
        pkt_valid = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
